// File: rtl/memory_game_pkg.sv
// Shared card-state codes, regfile entry sizing and FSM states for the
// pair-matching game.
package memory_game_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] CARD_HIDDEN  = 2'b00;
    localparam logic [STATE_W-1:0] CARD_FACEUP  = 2'b11;
    localparam logic [STATE_W-1:0] CARD_MATCHED = 2'b10;

    function automatic int unsigned entry_width(input int unsigned color_w);
        return color_w + STATE_W;
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_RD1,
        ST_CHK1,
        ST_WAIT_SECOND,
        ST_RD2,
        ST_CHK2,
        ST_SHOW,
        ST_RESOLVE_A,
        ST_RESOLVE_B,
        ST_DONE
    } game_state_e;

endpackage

// File: rtl/reveal_timer.sv
// Down-counter holding both cards face-up: load arms it with TICKS-1,
// count decrements while active, expired_o flags the zero count.
module reveal_timer #(
    parameter int unsigned TICKS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int unsigned W = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(TICKS - 1);
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/card_pair_ctl.sv
// Pair-matching game controller: reveals two clicked cards, compares colours,
// then after a visible delay marks them matched or hides them again.
module card_pair_ctl
    import memory_game_pkg::*;
#(
    parameter int unsigned NUM_CARDS    = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned COLOR_W      = 12,
    parameter int unsigned REVEAL_TICKS = 65_000_000,
    parameter int unsigned MOVES_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 click_valid,
    input  logic [ADDR_W-1:0]                    click_addr,
    output logic [ADDR_W-1:0]                    rf_rd_addr,
    input  logic [entry_width(COLOR_W)-1:0]      rf_rd_data,
    output logic                                 rf_wr_en,
    output logic [ADDR_W-1:0]                    rf_wr_addr,
    output logic [entry_width(COLOR_W)-1:0]      rf_wr_data,
    output logic                                 busy,
    output logic                                 match_pulse,
    output logic                                 game_done,
    output logic [MOVES_W-1:0]                   moves,
    output logic [$clog2(NUM_CARDS/2+1)-1:0]     pairs_found
);

    localparam int unsigned        PAIRS_W    = $clog2(NUM_CARDS/2+1);
    localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W+1)'(NUM_CARDS);
    localparam logic [PAIRS_W-1:0] PAIRS_ALL  = PAIRS_W'(NUM_CARDS/2);

    game_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    addr1_q, addr1_d;
    logic [ADDR_W-1:0]    addr2_q, addr2_d;
    logic [COLOR_W-1:0]   col1_q, col1_d;
    logic [COLOR_W-1:0]   col2_q, col2_d;
    logic                 match_q, match_d;
    logic [MOVES_W-1:0]   moves_q, moves_d;
    logic [PAIRS_W-1:0]   pairs_q, pairs_d;

    logic                 click_ok;
    logic                 tmr_load;
    logic                 tmr_expired;
    logic [COLOR_W-1:0]   rd_col;
    logic [STATE_W-1:0]   rd_st;
    logic [STATE_W-1:0]   res_st;
    logic [PAIRS_W-1:0]   pairs_inc;

    assign click_ok  = click_valid && ({1'b0, click_addr} < ADDR_LIMIT);
    assign rd_col    = rf_rd_data[COLOR_W+STATE_W-1:STATE_W];
    assign rd_st     = rf_rd_data[STATE_W-1:0];
    assign res_st    = match_q ? CARD_MATCHED : CARD_HIDDEN;
    assign pairs_inc = pairs_q + PAIRS_W'(1);

    reveal_timer #(
        .TICKS(REVEAL_TICKS)
    ) u_reveal_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load_i   (tmr_load),
        .count_i  (state_q == ST_SHOW),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        col1_d      = col1_q;
        col2_d      = col2_q;
        match_d     = match_q;
        moves_d     = moves_q;
        pairs_d     = pairs_q;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        match_pulse = 1'b0;
        tmr_load    = 1'b0;

        // start overrides everything, including any write due this cycle
        if (start) begin
            state_d = ST_WAIT_FIRST;
            moves_d = '0;
            pairs_d = '0;
            match_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: ;
                ST_WAIT_FIRST: begin
                    if (click_ok) begin
                        rd_addr_d = click_addr;
                        addr1_d   = click_addr;
                        state_d   = ST_RD1;
                    end
                end
                ST_RD1: state_d = ST_CHK1;
                ST_CHK1: begin
                    if (rd_st != CARD_HIDDEN) begin
                        state_d = ST_WAIT_FIRST;
                    end else begin
                        col1_d     = rd_col;
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = addr1_q;
                        rf_wr_data = {rd_col, CARD_FACEUP};
                        state_d    = ST_WAIT_SECOND;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (click_ok) begin
                        rd_addr_d = click_addr;
                        addr2_d   = click_addr;
                        state_d   = ST_RD2;
                    end
                end
                ST_RD2: state_d = ST_CHK2;
                ST_CHK2: begin
                    if (rd_st != CARD_HIDDEN) begin
                        state_d = ST_WAIT_SECOND;
                    end else begin
                        col2_d     = rd_col;
                        match_d    = (rd_col == col1_q);
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = addr2_q;
                        rf_wr_data = {rd_col, CARD_FACEUP};
                        tmr_load   = 1'b1;
                        if (moves_q != '1) begin
                            moves_d = moves_q + MOVES_W'(1);
                        end
                        state_d    = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (tmr_expired) begin
                        state_d = ST_RESOLVE_A;
                    end
                end
                ST_RESOLVE_A: begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = addr1_q;
                    rf_wr_data = {col1_q, res_st};
                    state_d    = ST_RESOLVE_B;
                end
                ST_RESOLVE_B: begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = addr2_q;
                    rf_wr_data = {col2_q, res_st};
                    state_d    = ST_WAIT_FIRST;
                    if (match_q) begin
                        match_pulse = 1'b1;
                        pairs_d     = pairs_inc;
                        if (pairs_inc == PAIRS_ALL) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            col1_q    <= '0;
            col2_q    <= '0;
            match_q   <= 1'b0;
            moves_q   <= '0;
            pairs_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            col1_q    <= col1_d;
            col2_q    <= col2_d;
            match_q   <= match_d;
            moves_q   <= moves_d;
            pairs_q   <= pairs_d;
        end
    end

    assign busy        = !(state_q inside {ST_IDLE, ST_WAIT_FIRST, ST_WAIT_SECOND, ST_DONE});
    assign game_done   = (state_q == ST_DONE);
    assign moves       = moves_q;
    assign pairs_found = pairs_q;
    assign rf_rd_addr  = rd_addr_q;

endmodule
